led_fader: RTL and testbench

Downstream output stage for the LED shifter. It takes the 8-bit LED pattern and drives the 8 physical LED pins with per-channel PWM. A channel jumps to full brightness while its pattern bit is 1, then fades out in fixed steps after the bit drops, leaving a comet-tail trail behind the rotating pattern. The block runs in the same clock domain as its pattern source and sits between that source and the board pins.

---
 rtl/led_pkg.sv | 22 ++
 rtl/led_fader_channel.sv | 47 ++++
 rtl/led_fader.sv | 70 +++++++
 tb/tb_led_fader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED output stage.
package led_pkg;

    localparam int LED_COUNT = 8;
    localparam int LEVEL_W   = 8;

    typedef logic [LEVEL_W-1:0] led_level_t;

    localparam led_level_t LEVEL_MAX = 8'hFF;

    // Subtract one decay step, clamping at zero so a dim channel never wraps to bright.
    function automatic led_level_t sat_decay(input led_level_t level, input led_level_t step);
        led_level_t result;
        if (level > step) begin
            result = level - step;
        end else begin
            result = 8'd0;
        end
        return result;
    endfunction

endpackage

// File: rtl/led_fader_channel.sv
// One LED channel: brightness level register plus its PWM compare.
module led_fader_channel
    import led_pkg::*;
#(
    parameter int DECAY_STEP = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lit,
    input  led_level_t max_level,
    input  logic       tick,
    input  logic [7:0] pwm_cnt,
    output logic       pwm
);

    localparam led_level_t STEP = led_level_t'(DECAY_STEP);

    led_level_t level_q;
    led_level_t level_d;
    logic       pwm_q;

    // Next level: a lit bit reloads (beating any tick), otherwise a tick decays, otherwise hold.
    always_comb begin
        level_d = level_q;
        if (lit) begin
            level_d = max_level;
        end else if (tick) begin
            level_d = sat_decay(level_q, STEP);
        end else begin
            level_d = level_q;
        end
    end

    // Level register and registered PWM compare; full level is forced constantly on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 8'd0;
            pwm_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            pwm_q   <= (level_q == LEVEL_MAX) | (pwm_cnt < level_q);
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/led_fader.sv
// LED output stage: per-channel PWM with a stepped fade after each pattern bit drops.
module led_fader
    import led_pkg::*;
#(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int DECAY_HZ   = 64,
    parameter int DECAY_STEP = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LED_COUNT-1:0] pattern_in,
    input  led_level_t           max_level,
    output logic [LED_COUNT-1:0] pwm_out,
    output logic                 tick_o
);

    localparam int          TICK_CYCLES = CLK_FREQ / DECAY_HZ;
    localparam logic [31:0] TICK_LAST   = 32'(TICK_CYCLES - 1);

    logic [31:0]          tick_cnt_q;
    logic [31:0]          tick_cnt_d;
    logic [7:0]           pwm_cnt_q;
    logic [7:0]           pwm_cnt_d;
    logic                 tick_o_q;
    logic                 tick_s;
    logic [LED_COUNT-1:0] pwm_s;

    // Tick divider and free-running PWM ramp; neither is re-phased by the pattern.
    always_comb begin
        tick_s     = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick_cnt_q + 32'd1;
        if (tick_s) begin
            tick_cnt_d = 32'd0;
        end else begin
            tick_cnt_d = tick_cnt_q + 32'd1;
        end
        pwm_cnt_d = pwm_cnt_q + 8'd1;
    end

    // Counter state and the registered one-cycle tick pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= 32'd0;
            pwm_cnt_q  <= 8'd0;
            tick_o_q   <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            tick_o_q   <= tick_s;
        end
    end

    for (genvar i = 0; i < LED_COUNT; i++) begin : g_chan
        led_fader_channel #(
            .DECAY_STEP (DECAY_STEP)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .lit       (pattern_in[i]),
            .max_level (max_level),
            .tick      (tick_s),
            .pwm_cnt   (pwm_cnt_q),
            .pwm       (pwm_s[i])
        );
    end

    assign pwm_out = pwm_s;
    assign tick_o  = tick_o_q;

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader: cycle-level behavioural model plus directed duty checks.
module tb_led_fader;

    localparam int TICK = 256;
    localparam int STEP = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pat;
    logic [7:0] mx;
    logic [7:0] pwm_out;
    logic       tick_o;

    int checks = 0;
    int errors = 0;

    // Behavioural model: edges since reset, per-channel brightness, expected outputs.
    int unsigned cyc;
    int          lvl [8];
    logic [7:0]  exp_pwm;
    logic        exp_tick;

    led_fader #(
        .CLK_FREQ   (1024),
        .DECAY_HZ   (4),
        .DECAY_STEP (STEP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pattern_in (pat),
        .max_level  (mx),
        .pwm_out    (pwm_out),
        .tick_o     (tick_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        cyc      = 0;
        exp_pwm  = 8'h00;
        exp_tick = 1'b0;
        for (int i = 0; i < 8; i++) lvl[i] = 0;
    endtask

    // One clock: advance the model on the edge, then compare both outputs.
    task automatic step();
        bit tick_now;
        int pc;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            tick_now = ((cyc % TICK) == TICK - 1);
            pc = int'(cyc % 256);
            for (int i = 0; i < 8; i++) exp_pwm[i] = (lvl[i] == 255) || (pc < lvl[i]);
            for (int i = 0; i < 8; i++) begin
                if (pat[i]) lvl[i] = int'(mx);
                else if (tick_now) lvl[i] = (lvl[i] > STEP) ? lvl[i] - STEP : 0;
            end
            exp_tick = tick_now;
            cyc++;
        end
        #1;
        chk("pwm_out", 32'(pwm_out), 32'(exp_pwm));
        chk("tick_o", 32'(tick_o), 32'(exp_tick));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Advance until the next edge starts a fresh PWM/tick window (bounded).
    task automatic sync_window();
        int guard = 0;
        step();
        while ((cyc % TICK) != 0 && guard < 600) begin
            step();
            guard++;
        end
        chk("sync_bound", 32'(guard < 600), 32'd1);
    endtask

    task automatic window(input int b, output int cnt);
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            if (pwm_out[b] === 1'b1) cnt++;
        end
    endtask

    initial begin
        int first_tick;
        int cnt;
        int guard;
        int duty_exp [4];
        duty_exp = '{191, 127, 63, 0};

        pat   = 8'h00;
        mx    = 8'h00;
        rst_n = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        steps(3);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: dark outputs, tick every 256 cycles with the first after edge 256.
        first_tick = 0;
        for (int k = 1; k <= 520; k++) begin
            step();
            if (tick_o === 1'b1 && first_tick == 0) first_tick = k;
        end
        chk("first_tick_edge", 32'(first_tick), 32'd256);

        // Full brightness on bit 0, constant on from the second edge.
        pat = 8'h01;
        mx  = 8'hFF;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (k == 1) chk("lit_latency", 32'(pwm_out), 32'h00);
            else if (k == 2 || k == 150 || k == 300) chk("lit_const_on", 32'(pwm_out), 32'h01);
        end

        // Fade: duty per window after each successive tick.
        pat = 8'h00;
        sync_window();
        for (int w = 0; w < 4; w++) begin
            window(0, cnt);
            chk("fade_duty", 32'(cnt), 32'(duty_exp[w]));
        end

        // Partial brightness, then zero brightness, on bit 3.
        pat = 8'h08;
        mx  = 8'd100;
        steps(2);
        sync_window();
        window(3, cnt);
        chk("duty_100", 32'(cnt), 32'd100);
        mx = 8'd0;
        steps(2);
        sync_window();
        window(3, cnt);
        chk("duty_0", 32'(cnt), 32'd0);

        // Load on bit 5 exactly at a tick edge: no decay applied.
        pat = 8'h00;
        guard = 0;
        while ((cyc % TICK) != TICK - 1 && guard < 600) begin
            step();
            guard++;
        end
        pat = 8'h20;
        mx  = 8'd200;
        step();
        pat = 8'h00;
        window(5, cnt);
        chk("load_beats_tick", 32'(cnt), 32'd200);

        // Saturation: level 40 with step 64 decays to 0.
        pat = 8'h20;
        mx  = 8'd40;
        step();
        pat = 8'h00;
        sync_window();
        window(5, cnt);
        chk("saturate_zero", 32'(cnt), 32'd0);

        // Randomized pattern/brightness against the model.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(7, 0) == 0) pat = 8'($urandom);
            if ($urandom_range(31, 0) == 0) begin
                case ($urandom_range(3, 0))
                    0:       mx = 8'hFF;
                    1:       mx = 8'h00;
                    default: mx = 8'($urandom);
                endcase
            end
            step();
        end

        // Asynchronous reset mid-fade.
        pat = 8'hFF;
        mx  = 8'hFF;
        steps(3);
        pat = 8'h00;
        steps(10);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pwm", 32'(pwm_out), 32'h00);
        chk("async_rst_tick", 32'(tick_o), 32'h0);
        steps(3);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 600; k++) begin
            step();
            if (k % 100 == 0) chk("dark_after_reset", 32'(pwm_out), 32'h00);
        end
        pat = 8'h80;
        mx  = 8'hFF;
        steps(5);
        chk("relight_after_reset", 32'(pwm_out), 32'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
